// File: rtl/debug_hex_monitor.sv
// Debug display selector: picks one of NUM_CH debug words, pages it onto
// active-low 7-segment digits, stepped by debounced buttons or an auto timer.
module debug_hex_monitor #(
  parameter int NUM_CH       = 8,
  parameter int DATA_W       = 32,
  parameter int NUM_DIGITS   = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int AUTO_CYC     = 50000000,
  localparam int PAGES = (DATA_W + 4 * NUM_DIGITS - 1) / (4 * NUM_DIGITS),
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PG_W  = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     btn_next,
  input  logic                     btn_page,
  input  logic                     sw_auto,
  input  logic                     sw_freeze,
  output logic [NUM_DIGITS*7-1:0]  hex_out,
  output logic [CH_W-1:0]          ch_idx,
  output logic [PG_W-1:0]          page_idx,
  output logic                     frozen
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int AT_W   = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;
  localparam int PAGE_W = 4 * NUM_DIGITS;
  localparam int PAD_W  = PAGES * PAGE_W;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_CYC - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [PG_W-1:0] PG_LAST = PG_W'(PAGES - 1);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Bit 0 = next button / auto switch, bit 1 = page button / freeze switch.
  logic [1:0]            btn_meta_r, btn_sync_r;
  logic [1:0]            sw_meta_r, sw_sync_r;
  logic [1:0]            btn_deb_r;
  logic [DB_W-1:0]       db_cnt_r [2];
  logic [1:0]            db_accept_s, press_s;
  logic [AT_W-1:0]       auto_cnt_r;
  logic                  auto_tick_s, advance_s;
  logic [CH_W-1:0]       ch_idx_r;
  logic [PG_W-1:0]       page_idx_r;
  logic                  frozen_r;
  logic [DATA_W-1:0]     snapshot_r [NUM_CH];
  logic [DATA_W-1:0]     word_s;
  logic [PAD_W-1:0]      padded_s;
  logic [PAGE_W-1:0]     page_word_s;
  logic [NUM_DIGITS*7-1:0] hex_next_s, hex_r;

  // Two-flop synchronisers; buttons idle released, switches idle off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= 2'b11;
      btn_sync_r <= 2'b11;
      sw_meta_r  <= 2'b00;
      sw_sync_r  <= 2'b00;
    end else begin
      btn_meta_r <= {btn_page, btn_next};
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= {sw_freeze, sw_auto};
      sw_sync_r  <= sw_meta_r;
    end
  end

  // A level is accepted after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    db_accept_s = 2'b00;
    press_s     = 2'b00;
    for (int b = 0; b < 2; b++) begin
      db_accept_s[b] = (btn_sync_r[b] != btn_deb_r[b]) && (db_cnt_r[b] == DB_LAST);
      press_s[b]     = db_accept_s[b] & ~btn_sync_r[b];
    end
  end

  // Debounce state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_deb_r <= 2'b11;
      for (int b = 0; b < 2; b++) db_cnt_r[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (btn_sync_r[b] == btn_deb_r[b]) begin
          db_cnt_r[b] <= '0;
        end else if (db_accept_s[b]) begin
          btn_deb_r[b] <= btn_sync_r[b];
          db_cnt_r[b]  <= '0;
        end else begin
          db_cnt_r[b] <= db_cnt_r[b] + DB_W'(1);
        end
      end
    end
  end

  assign auto_tick_s = sw_sync_r[0] && (auto_cnt_r == AT_LAST);
  assign advance_s   = press_s[0] | auto_tick_s;

  // Auto-cycle interval; a manual step restarts the full interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_r <= '0;
    end else if (!sw_sync_r[0] || press_s[0] || auto_tick_s) begin
      auto_cnt_r <= '0;
    end else begin
      auto_cnt_r <= auto_cnt_r + AT_W'(1);
    end
  end

  // Channel/page selection; a channel step always returns to page 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx_r   <= '0;
      page_idx_r <= '0;
    end else if (advance_s) begin
      ch_idx_r   <= (ch_idx_r == CH_LAST) ? '0 : ch_idx_r + CH_W'(1);
      page_idx_r <= '0;
    end else if (press_s[1]) begin
      page_idx_r <= (page_idx_r == PG_LAST) ? '0 : page_idx_r + PG_W'(1);
    end else begin
      page_idx_r <= page_idx_r;
    end
  end

  // Snapshot tracks the live channels until frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_r <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) snapshot_r[k] <= '0;
    end else begin
      frozen_r <= sw_sync_r[1];
      if (!frozen_r) begin
        for (int k = 0; k < NUM_CH; k++) snapshot_r[k] <= ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Word/page select and glyph encode; bits past DATA_W read as zero.
  always_comb begin
    if (ch_idx_r <= CH_LAST) begin
      word_s = snapshot_r[ch_idx_r];
    end else begin
      word_s = '0;
    end
    padded_s               = '0;
    padded_s[DATA_W-1:0]   = word_s;
    page_word_s            = PAGE_W'(padded_s >> (32'(page_idx_r) * 32'(PAGE_W)));
    hex_next_s             = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hex_next_s[d*7 +: 7] = seg7(page_word_s[d*4 +: 4]);
    end
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_r <= {NUM_DIGITS{7'h40}};
    end else begin
      hex_r <= hex_next_s;
    end
  end

  assign hex_out  = hex_r;
  assign ch_idx   = ch_idx_r;
  assign page_idx = page_idx_r;
  assign frozen   = frozen_r;

endmodule

// File: tb/tb_debug_hex_monitor.sv
// Directed self-checking bench for debug_hex_monitor (3 channels, short timers).
module tb_debug_hex_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] ch_data;
  logic        btn_next, btn_page, sw_auto, sw_freeze;
  logic [27:0] hex_out;
  logic [1:0]  ch_idx;
  logic [0:0]  page_idx;
  logic        frozen;

  int checks = 0;
  int errors = 0;
  int n;

  debug_hex_monitor #(
    .NUM_CH(3), .DATA_W(32), .NUM_DIGITS(4), .DEBOUNCE_CYC(4), .AUTO_CYC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .btn_next(btn_next),
    .btn_page(btn_page), .sw_auto(sw_auto), .sw_freeze(sw_freeze),
    .hex_out(hex_out), .ch_idx(ch_idx), .page_idx(page_idx), .frozen(frozen)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
      4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
      4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
      4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; 4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  endfunction

  // Digits listed most-significant (digit 3) first.
  function automatic logic [27:0] hex4(input logic [3:0] d3, input logic [3:0] d2,
                                       input logic [3:0] d1, input logic [3:0] d0);
    hex4 = {seg(d3), seg(d2), seg(d1), seg(d0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input bit which);
    if (which) btn_page = 1'b0; else btn_next = 1'b0;
    cycles(10);
    if (which) btn_page = 1'b1; else btn_next = 1'b1;
    cycles(10);
  endtask

  // Counts negedges until ch_idx moves (bounded); optionally releases btn_next.
  task automatic wait_step(input int bound, input int release_at, output int cnt);
    logic [1:0] start;
    start = ch_idx;
    cnt = 0;
    while (ch_idx == start && cnt < bound) begin
      @(negedge clk);
      cnt++;
      if (cnt == release_at) btn_next = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn_next = 1'b1; btn_page = 1'b1; sw_auto = 1'b0; sw_freeze = 1'b0;
    ch_data = {32'h0F1E2D3C, 32'hAABBCCDD, 32'h12345678};
    cycles(3);
    check("rst_ch", 32'(ch_idx), 32'd0);
    check("rst_page", 32'(page_idx), 32'd0);
    check("rst_frozen", 32'(frozen), 32'd0);
    check("rst_hex", 32'(hex_out), 32'(hex4(4'h0, 4'h0, 4'h0, 4'h0)));
    rst_n = 1'b1;
    cycles(4);
    check("post_rst_ch", 32'(ch_idx), 32'd0);
    check("post_rst_hex", 32'(hex_out), 32'(hex4(4'h5, 4'h6, 4'h7, 4'h8)));

    // Paging
    press(1'b1);
    check("page1_idx", 32'(page_idx), 32'd1);
    check("page1_hex", 32'(hex_out), 32'(hex4(4'h1, 4'h2, 4'h3, 4'h4)));
    press(1'b1);
    check("page_wrap", 32'(page_idx), 32'd0);

    // Channel stepping with page reset and wrap
    press(1'b1);
    press(1'b0);
    check("next1_ch", 32'(ch_idx), 32'd1);
    check("next1_page", 32'(page_idx), 32'd0);
    check("next1_hex", 32'(hex_out), 32'(hex4(4'hC, 4'hC, 4'hD, 4'hD)));
    press(1'b0);
    check("next2_ch", 32'(ch_idx), 32'd2);
    check("ch2_p0_hex", 32'(hex_out), 32'(hex4(4'h2, 4'hD, 4'h3, 4'hC)));
    press(1'b1);
    check("ch2_p1_hex", 32'(hex_out), 32'(hex4(4'h0, 4'hF, 4'h1, 4'hE)));
    press(1'b0);
    check("next_wrap_ch", 32'(ch_idx), 32'd0);
    check("next_wrap_page", 32'(page_idx), 32'd0);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b0; cycles(2);
      btn_next = 1'b1; cycles(2);
    end
    cycles(10);
    check("bounce_ch", 32'(ch_idx), 32'd0);

    // Freeze
    ch_data[31:0] = 32'hDEADBEEF;
    cycles(3);
    sw_freeze = 1'b1;
    cycles(5);
    check("frozen_set", 32'(frozen), 32'd1);
    ch_data = 96'h0;
    cycles(5);
    check("frz_beef", 32'(hex_out), 32'(hex4(4'hB, 4'hE, 4'hE, 4'hF)));
    press(1'b1);
    check("frz_dead", 32'(hex_out), 32'(hex4(4'hD, 4'hE, 4'hA, 4'hD)));
    press(1'b0);
    check("frz_ch1", 32'(ch_idx), 32'd1);
    check("frz_ch1_hex", 32'(hex_out), 32'(hex4(4'hC, 4'hC, 4'hD, 4'hD)));
    sw_freeze = 1'b0;
    cycles(6);
    check("unfrozen", 32'(frozen), 32'd0);
    check("unfrz_hex", 32'(hex_out), 32'(hex4(4'h0, 4'h0, 4'h0, 4'h0)));

    // Auto cycle
    sw_auto = 1'b1;
    wait_step(40, -1, n);
    check("auto_first_ch", 32'(ch_idx), 32'd2);
    wait_step(30, -1, n);
    check("auto_interval", 32'(n), 32'd10);
    check("auto_wrap_ch", 32'(ch_idx), 32'd0);
    cycles(1);
    btn_next = 1'b0;
    wait_step(20, -1, n);
    check("auto_press_ch", 32'(ch_idx), 32'd1);
    wait_step(30, 4, n);
    check("auto_restart_interval", 32'(n), 32'd10);
    check("auto_restart_ch", 32'(ch_idx), 32'd2);
    sw_auto = 1'b0;
    cycles(25);
    check("auto_off_ch", 32'(ch_idx), 32'd2);

    // Simultaneous next and page events: advance wins
    press(1'b1);
    check("coll_pre_page", 32'(page_idx), 32'd1);
    btn_next = 1'b0; btn_page = 1'b0;
    cycles(10);
    btn_next = 1'b1; btn_page = 1'b1;
    cycles(10);
    check("coll_ch", 32'(ch_idx), 32'd0);
    check("coll_page", 32'(page_idx), 32'd0);

    // Reset mid-debounce discards progress
    press(1'b0);
    press(1'b1);
    sw_freeze = 1'b1;
    cycles(5);
    btn_next = 1'b0;
    cycles(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ch", 32'(ch_idx), 32'd0);
    check("mid_rst_page", 32'(page_idx), 32'd0);
    check("mid_rst_frozen", 32'(frozen), 32'd0);
    check("mid_rst_hex", 32'(hex_out), 32'(hex4(4'h0, 4'h0, 4'h0, 4'h0)));
    sw_freeze = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    btn_next = 1'b1;
    cycles(15);
    check("post_mid_rst_ch", 32'(ch_idx), 32'd0);
    check("post_mid_rst_page", 32'(page_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
